// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the memory port arbiter.
// The slave modport is the arbiter's view; master is the view of the core plus memory.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        write_mem;
    logic [2:0]  funct3;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic [31:0] read_address;
    logic [31:0] read_data;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_funct3, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output write_mem, funct3, write_address, write_data, read_address,
        input  read_data
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_funct3, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  write_mem, funct3, write_address, write_data, read_address,
        output read_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single RV32I memory port between instruction fetch and load/store, data first with fetch anti-starvation.
// Optional MEM_ARB_PERF_EN adds grant and stall counters as extra outputs.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]         if_grant_cnt,
    output logic [31:0]         d_grant_cnt,
    output logic [31:0]         stall_cnt
`endif
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_IF,
        OWNER_D
    } owner_t;

    owner_t      owner;
    logic [3:0]  starve_cnt;
    logic        if_rvalid_q;
    logic        d_rvalid_q;
    logic [31:0] read_addr_q;
    logic [31:0] write_addr_q;
    logic [31:0] write_data_q;

    logic fetch_win;
    logic if_gnt_c;
    logic d_gnt_c;
    logic d_load_c;
    logic d_store_c;

    // Data normally wins; a fetch that has waited STARVE_LIMIT cycles takes the port.
    always_comb begin
        fetch_win = bus.if_req && (!bus.d_req || (starve_cnt == LIMIT));
        if_gnt_c  = !reset && fetch_win;
        d_gnt_c   = !reset && bus.d_req && !fetch_win;
        d_load_c  = d_gnt_c && !bus.d_we;
        d_store_c = d_gnt_c && bus.d_we;
    end

    assign bus.if_gnt        = if_gnt_c;
    assign bus.d_gnt         = d_gnt_c;
    assign bus.write_mem     = d_store_c;
    assign bus.funct3        = d_gnt_c ? bus.d_funct3 : FUNCT3_WORD;
    assign bus.read_address  = if_gnt_c ? bus.if_addr :
                               (d_load_c ? bus.d_addr : read_addr_q);
    assign bus.write_address = d_store_c ? bus.d_addr : write_addr_q;
    assign bus.write_data    = d_store_c ? bus.d_wdata : write_data_q;

    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = if_rvalid_q ? bus.read_data : 32'h0;
    assign bus.d_rdata   = d_rvalid_q ? bus.read_data : 32'h0;

    // Owner of the in-flight read, its registered rvalid, held addresses and the starvation counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner        <= OWNER_NONE;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            starve_cnt   <= 4'd0;
            read_addr_q  <= 32'h0;
            write_addr_q <= 32'h0;
            write_data_q <= 32'h0;
        end else begin
            if (if_gnt_c) begin
                owner       <= OWNER_IF;
                if_rvalid_q <= 1'b1;
                d_rvalid_q  <= 1'b0;
            end else if (d_load_c) begin
                owner       <= OWNER_D;
                if_rvalid_q <= 1'b0;
                d_rvalid_q  <= 1'b1;
            end else begin
                owner       <= OWNER_NONE;
                if_rvalid_q <= 1'b0;
                d_rvalid_q  <= 1'b0;
            end

            read_addr_q  <= bus.read_address;
            write_addr_q <= bus.write_address;
            write_data_q <= bus.write_data;

            if (!bus.if_req || if_gnt_c) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    // Free-running performance counters; a stall is any cycle with a pending request left ungranted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_grant_cnt <= 32'h0;
            d_grant_cnt  <= 32'h0;
            stall_cnt    <= 32'h0;
        end else begin
            if (if_gnt_c) begin
                if_grant_cnt <= if_grant_cnt + 32'h1;
            end
            if (d_gnt_c) begin
                d_grant_cnt <= d_grant_cnt + 32'h1;
            end
            if ((bus.if_req && !if_gnt_c) || (bus.d_req && !d_gnt_c)) begin
                stall_cnt <= stall_cnt + 32'h1;
            end
        end
    end
`endif

    // A requester must hold its request until it has been granted.
    if_req_held : assert property (@(posedge clk) disable iff (reset)
        (bus.if_req && !bus.if_gnt) |=> bus.if_req);
    d_req_held : assert property (@(posedge clk) disable iff (reset)
        (bus.d_req && !bus.d_gnt) |=> bus.d_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small 1-cycle-latency word memory.
// Define MEM_ARB_PERF_EN to also exercise the performance counters.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mem_port_arbiter_if bus ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] if_grant_cnt;
    logic [31:0] d_grant_cnt;
    logic [31:0] stall_cnt;
`endif

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef MEM_ARB_PERF_EN
        ,
        .if_grant_cnt (if_grant_cnt),
        .d_grant_cnt  (d_grant_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory indexed by addr[12:2]; preloaded while reset is high.
    logic [31:0] mem [0:2047];
    always @(posedge clk) begin
        if (reset) begin
            mem[0] <= 32'h0;
            mem[4] <= 32'hDEADBEEF;
            mem[8] <= 32'hCAFEF00D;
        end else if (bus.write_mem) begin
            mem[bus.write_address[12:2]] <= bus.write_data;
        end
        bus.read_data <= mem[bus.read_address[12:2]];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req   = 1'b0;
        bus.if_addr  = 32'h0;
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.d_funct3 = 3'b010;
        bus.d_addr   = 32'h0;
        bus.d_wdata  = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if (bus.if_gnt !== 1'b0) begin failures++; $display("[TB] FAIL reset_if_gnt got=%0b exp=0", bus.if_gnt); end
        checks++; if (bus.d_gnt !== 1'b0) begin failures++; $display("[TB] FAIL reset_d_gnt got=%0b exp=0", bus.d_gnt); end
        checks++; if (bus.write_mem !== 1'b0) begin failures++; $display("[TB] FAIL reset_write_mem got=%0b exp=0", bus.write_mem); end
        checks++; if (bus.funct3 !== 3'b010) begin failures++; $display("[TB] FAIL reset_funct3 got=%03b exp=010", bus.funct3); end
        checks++; if (bus.read_address !== 32'h0) begin failures++; $display("[TB] FAIL reset_read_address got=%08h exp=0", bus.read_address); end
        checks++; if (bus.write_address !== 32'h0) begin failures++; $display("[TB] FAIL reset_write_address got=%08h exp=0", bus.write_address); end
        checks++; if (bus.write_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_write_data got=%08h exp=0", bus.write_data); end
        checks++; if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rvalid got=%0b%0b exp=00", bus.if_rvalid, bus.d_rvalid); end
        next_cycle();
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_fetch();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        @(negedge clk);
        checks++; if (bus.if_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin failures++; $display("[TB] FAIL fetch_gnt got=%0b%0b exp=10", bus.if_gnt, bus.d_gnt); end
        checks++; if (bus.read_address !== 32'h10) begin failures++; $display("[TB] FAIL fetch_read_address got=%08h exp=00000010", bus.read_address); end
        checks++; if (bus.funct3 !== 3'b010 || bus.write_mem !== 1'b0) begin failures++; $display("[TB] FAIL fetch_funct3_we got=%03b/%0b exp=010/0", bus.funct3, bus.write_mem); end
        next_cycle();
        bus.if_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.if_rvalid !== 1'b1) begin failures++; $display("[TB] FAIL fetch_if_rvalid got=%0b exp=1", bus.if_rvalid); end
        checks++; if (bus.if_rdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL fetch_if_rdata got=%08h exp=deadbeef", bus.if_rdata); end
        checks++; if (bus.d_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL fetch_d_rvalid got=%0b exp=0", bus.d_rvalid); end
        checks++; if (bus.read_address !== 32'h10) begin failures++; $display("[TB] FAIL fetch_addr_hold got=%08h exp=00000010", bus.read_address); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.if_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL fetch_rvalid_single got=%0b exp=0", bus.if_rvalid); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h10;
        bus.d_req    = 1'b1;
        bus.d_we     = 1'b0;
        bus.d_funct3 = 3'b010;
        bus.d_addr   = 32'h20;
        @(negedge clk);
        checks++; if (bus.d_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin failures++; $display("[TB] FAIL b2b_first_gnt got d=%0b if=%0b exp d=1 if=0", bus.d_gnt, bus.if_gnt); end
        checks++; if (bus.read_address !== 32'h20) begin failures++; $display("[TB] FAIL b2b_load_addr got=%08h exp=00000020", bus.read_address); end
        next_cycle();
        bus.d_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL b2b_d_rdata got=%0b/%08h exp=1/cafef00d", bus.d_rvalid, bus.d_rdata); end
        checks++; if (bus.if_gnt !== 1'b1 || bus.read_address !== 32'h10) begin failures++; $display("[TB] FAIL b2b_second_gnt got=%0b/%08h exp=1/00000010", bus.if_gnt, bus.read_address); end
        checks++; if (bus.if_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_if_rvalid_early got=%0b exp=0", bus.if_rvalid); end
        next_cycle();
        bus.if_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hDEADBEEF || bus.d_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_if_rdata got=%0b/%08h d_rvalid=%0b exp=1/deadbeef d_rvalid=0", bus.if_rvalid, bus.if_rdata, bus.d_rvalid); end
        next_cycle();
    endtask

    task automatic test_starvation();
        logic exp_if;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h10;
        bus.d_req    = 1'b1;
        bus.d_we     = 1'b0;
        bus.d_funct3 = 3'b010;
        bus.d_addr   = 32'h20;
        for (int c = 1; c <= 6; c++) begin
            exp_if = (c == 5);
            @(negedge clk);
            checks++; if (bus.if_gnt !== exp_if || bus.d_gnt !== !exp_if) begin failures++; $display("[TB] FAIL starve_cycle%0d got if=%0b d=%0b exp if=%0b d=%0b", c, bus.if_gnt, bus.d_gnt, exp_if, !exp_if); end
            if (c == 6) begin
                checks++; if (bus.if_rvalid !== 1'b1 || bus.d_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL starve_rvalid_owner got if=%0b d=%0b exp if=1 d=0", bus.if_rvalid, bus.d_rvalid); end
            end
            next_cycle();
        end
        bus.d_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.if_gnt !== 1'b1) begin failures++; $display("[TB] FAIL starve_after_release got=%0b exp=1", bus.if_gnt); end
        next_cycle();
        bus.if_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_store_load();
        bus.d_req    = 1'b1;
        bus.d_we     = 1'b1;
        bus.d_funct3 = 3'b010;
        bus.d_addr   = 32'hFFFFFFFC;
        bus.d_wdata  = 32'h12345678;
        @(negedge clk);
        checks++; if (bus.d_gnt !== 1'b1 || bus.write_mem !== 1'b1) begin failures++; $display("[TB] FAIL store_gnt_we got=%0b/%0b exp=1/1", bus.d_gnt, bus.write_mem); end
        checks++; if (bus.write_address !== 32'hFFFFFFFC || bus.write_data !== 32'h12345678) begin failures++; $display("[TB] FAIL store_bus got=%08h/%08h exp=fffffffc/12345678", bus.write_address, bus.write_data); end
        next_cycle();
        bus.d_we = 1'b0;
        @(negedge clk);
        checks++; if (bus.write_mem !== 1'b0 || bus.d_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL store_no_rvalid got we=%0b rvalid=%0b exp 0/0", bus.write_mem, bus.d_rvalid); end
        checks++; if (bus.d_gnt !== 1'b1 || bus.read_address !== 32'hFFFFFFFC) begin failures++; $display("[TB] FAIL load_gnt got=%0b/%08h exp=1/fffffffc", bus.d_gnt, bus.read_address); end
        checks++; if (bus.write_address !== 32'hFFFFFFFC) begin failures++; $display("[TB] FAIL store_addr_hold got=%08h exp=fffffffc", bus.write_address); end
        next_cycle();
        bus.d_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h12345678) begin failures++; $display("[TB] FAIL load_rdata got=%0b/%08h exp=1/12345678", bus.d_rvalid, bus.d_rdata); end
        next_cycle();
    endtask

    task automatic test_funct3();
        bus.d_req    = 1'b1;
        bus.d_we     = 1'b0;
        bus.d_funct3 = 3'b101;
        bus.d_addr   = 32'h20;
        @(negedge clk);
        checks++; if (bus.funct3 !== 3'b101) begin failures++; $display("[TB] FAIL funct3_pass got=%03b exp=101", bus.funct3); end
        next_cycle();
        bus.d_req    = 1'b0;
        bus.d_funct3 = 3'b010;
        @(negedge clk);
        checks++; if (bus.funct3 !== 3'b010 || bus.d_rvalid !== 1'b1) begin failures++; $display("[TB] FAIL funct3_idle got=%03b rvalid=%0b exp=010/1", bus.funct3, bus.d_rvalid); end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        @(negedge clk);
        checks++; if (bus.if_gnt !== 1'b1) begin failures++; $display("[TB] FAIL rst_pre_gnt got=%0b exp=1", bus.if_gnt); end
        reset = 1'b1;
        #1;
        checks++; if (bus.if_gnt !== 1'b0 || bus.write_mem !== 1'b0 || bus.funct3 !== 3'b010) begin failures++; $display("[TB] FAIL rst_async_ctrl got gnt=%0b we=%0b f3=%03b exp 0/0/010", bus.if_gnt, bus.write_mem, bus.funct3); end
        checks++; if (bus.read_address !== 32'h0) begin failures++; $display("[TB] FAIL rst_async_addr got=%08h exp=0", bus.read_address); end
        next_cycle();
        bus.if_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.if_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rst_rvalid_dropped got=%0b exp=0", bus.if_rvalid); end
        next_cycle();
        reset = 1'b0;
        next_cycle();
        bus.if_req = 1'b1;
        next_cycle();
        bus.if_req = 1'b0;
        checks++; if (bus.if_rvalid !== 1'b1) begin failures++; $display("[TB] FAIL rst_rvalid_before got=%0b exp=1", bus.if_rvalid); end
        reset = 1'b1;
        #1;
        checks++; if (bus.if_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rst_rvalid_async got=%0b exp=0", bus.if_rvalid); end
        next_cycle();
        reset = 1'b0;
        next_cycle();
    endtask

`ifdef MEM_ARB_PERF_EN
    task automatic test_perf();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++; if (if_grant_cnt !== 32'd0 || d_grant_cnt !== 32'd0 || stall_cnt !== 32'd0) begin failures++; $display("[TB] FAIL perf_reset got=%0d/%0d/%0d exp=0/0/0", if_grant_cnt, d_grant_cnt, stall_cnt); end
        next_cycle();
        reset = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h20;
        next_cycle();
        bus.d_req = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        bus.if_req = 1'b0;
        bus.d_req  = 1'b1;
        next_cycle();
        bus.d_req = 1'b0;
        @(negedge clk);
        checks++; if (if_grant_cnt !== 32'd3) begin failures++; $display("[TB] FAIL perf_if_grants got=%0d exp=3", if_grant_cnt); end
        checks++; if (d_grant_cnt !== 32'd2) begin failures++; $display("[TB] FAIL perf_d_grants got=%0d exp=2", d_grant_cnt); end
        checks++; if (stall_cnt !== 32'd1) begin failures++; $display("[TB] FAIL perf_stalls got=%0d exp=1", stall_cnt); end
        next_cycle();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch();
        test_back_to_back();
        test_starvation();
        test_store_load();
        test_funct3();
        test_reset_mid_read();
`ifdef MEM_ARB_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
